// File: rtl/key_pulse_pkg.sv
// key_pulse_pkg: shared types and default constants for the pushbutton
// conditioning block (key_pulse_gen / key_debounce_ch).
//   key_state_t         - per-channel debounce FSM state, 2-bit encoding
//   *_DEF               - default timing at 50 MHz (10 ms debounce,
//                         0.5 s first repeat, 0.1 s repeat period)
// The default CNT_W only covers the debounce count. Builds that enable
// KEY_REPEAT_EN with the default repeat timing must widen CNT_W to 25.
package key_pulse_pkg;

   typedef enum logic [1:0] {
      StIdle        = 2'd0,
      StPressWait   = 2'd1,
      StPressed     = 2'd2,
      StReleaseWait = 2'd3
   } key_state_t;

   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned CNT_W_DEF           = 20;
   localparam int unsigned REPEAT_DELAY_DEF    = 25000000;
   localparam int unsigned REPEAT_RATE_DEF     = 5000000;

endpackage

// File: rtl/key_debounce_ch.sv
// key_debounce_ch: one pushbutton channel. A 2-flop synchronizer feeds a
// 4-state debounce FSM that accepts a level change only after
// DEBOUNCE_CYCLES consecutive stable samples.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat press pulses while held).
// Ports:
//   clk           - system clock
//   reset         - synchronous reset, active low
//   key_n         - raw pushbutton, active low, asynchronous to clk
//   key_level     - debounced level, 1 = pressed (registered)
//   press_pulse   - one-cycle pulse per accepted press / repeat (registered)
//   release_pulse - one-cycle pulse per accepted release (registered)
module key_debounce_ch
   import key_pulse_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] DbLast = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             key_s;
   key_state_t       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;

   // Synchronized key, inverted so that 1 means pressed.
   assign key_s = ~sync2_q;

`ifdef KEY_REPEAT_EN
   localparam logic [CNT_W-1:0] RepDelayLast = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] RepRateLast  = CNT_W'(REPEAT_RATE - 1);

   logic [CNT_W-1:0] rep_cnt_q;
   logic             rep_first_q;
   logic [CNT_W-1:0] rep_limit;

   // First repeat waits the long delay, later ones the short period.
   assign rep_limit = rep_first_q ? RepDelayLast : RepRateLast;
`else
   logic unused_repeat_cfg;
   assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_RATE};
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         state_q     <= StIdle;
         cnt_q       <= '0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
`ifdef KEY_REPEAT_EN
         rep_cnt_q   <= '0;
         rep_first_q <= 1'b1;
`endif
      end else begin
         sync1_q   <= key_n;
         sync2_q   <= sync1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (key_s) begin
                  state_q <= StPressWait;
                  cnt_q   <= CNT_W'(1);
               end
            end
            StPressWait: begin
               if (!key_s) begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end else if (cnt_q == DbLast) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
                  level_q <= 1'b1;
                  press_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            StPressed: begin
               if (!key_s) begin
                  state_q <= StReleaseWait;
                  cnt_q   <= CNT_W'(1);
               end
`ifdef KEY_REPEAT_EN
               else if (rep_cnt_q == rep_limit) begin
                  press_q     <= 1'b1;
                  rep_cnt_q   <= '0;
                  rep_first_q <= 1'b0;
               end else begin
                  rep_cnt_q <= rep_cnt_q + 1'b1;
               end
`endif
            end
            StReleaseWait: begin
               // Repeat counter stays frozen here; a bounce back resumes it.
               if (key_s) begin
                  state_q <= StPressed;
                  cnt_q   <= '0;
               end else if (cnt_q == DbLast) begin
                  state_q     <= StIdle;
                  cnt_q       <= '0;
                  level_q     <= 1'b0;
                  release_q   <= 1'b1;
`ifdef KEY_REPEAT_EN
                  rep_cnt_q   <= '0;
                  rep_first_q <= 1'b1;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   assign key_level     = level_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;

endmodule

// File: rtl/key_pulse_gen.sv
// key_pulse_gen: conditions NUM_KEYS raw active-low pushbuttons into
// debounced levels plus single-cycle press/release pulses, one independent
// key_debounce_ch per key. All outputs are registered in the clk domain.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat press pulses while held).
// Ports:
//   clk           - system clock
//   reset         - synchronous reset, active low
//   key_n         - raw pushbuttons [NUM_KEYS], active low, asynchronous
//   key_level     - debounced levels [NUM_KEYS], 1 = pressed
//   press_pulse   - one-cycle press (and repeat) pulses [NUM_KEYS]
//   release_pulse - one-cycle release pulses [NUM_KEYS]
module key_pulse_gen
   import key_pulse_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 4,
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF,
   parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
   parameter int unsigned REPEAT_RATE     = REPEAT_RATE_DEF
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] key_level,
   output logic [NUM_KEYS-1:0] press_pulse,
   output logic [NUM_KEYS-1:0] release_pulse
);

   for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
      key_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE)
      ) u_ch (
         .clk           (clk),
         .reset         (reset),
         .key_n         (key_n[i]),
         .key_level     (key_level[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_key_pulse_gen.sv
// tb_key_pulse_gen: bench for key_pulse_gen with DEBOUNCE_CYCLES=4, CNT_W=4,
// REPEAT_DELAY=10, REPEAT_RATE=3. Follows KEY_REPEAT_EN like the design.
// The per-cycle reference treats each key as a level that flips once the
// last DEBOUNCE_CYCLES synchronized samples all disagree with it.
module tb_key_pulse_gen;

   localparam int NK = 4;
   localparam int DB = 4;
   localparam int CW = 4;
   localparam int RD = 10;
   localparam int RR = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [NK-1:0] key_n = '1;
   logic [NK-1:0] key_level;
   logic [NK-1:0] press_pulse;
   logic [NK-1:0] release_pulse;

   always #5 clk = ~clk;

   key_pulse_gen #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (CW),
      .REPEAT_DELAY    (RD),
      .REPEAT_RATE     (RR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .key_n         (key_n),
      .key_level     (key_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   typedef struct {
      string      name;
      logic       rst;
      logic [3:0] kn;
      int         cycles;
      int         ep_bits;   // total press-pulse bits in segment
      int         ep_idx;    // cycle (1-based) of first press pulse, 0 = none
      logic [3:0] ep_vec;    // press_pulse vector at that cycle
      int         er_bits;
      int         er_idx;
      logic [3:0] er_vec;
      logic [3:0] lvl_end;   // key_level after the last cycle
   } seg_t;

   typedef struct packed {
      logic [3:0] lvl;
      logic [3:0] pp;
      logic [3:0] rp;
   } exp_t;

   seg_t segs[$];
   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   logic m_sync1 [NK];
   logic m_sync2 [NK];
   logic m_level [NK];
   int   m_run   [NK];
   int   m_rep   [NK];

   int         cyc_in_seg;
   int         obs_pbits, obs_pidx, obs_rbits, obs_ridx;
   logic [3:0] obs_pvec, obs_rvec;
   int         press_hist[$];
   int         exp_rep[$];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic add_seg(input string nm, input logic rst, input logic [3:0] kn,
                          input int cyc, input int pb, input int pi, input logic [3:0] pv,
                          input int rb, input int ri, input logic [3:0] rv,
                          input logic [3:0] lv);
      seg_t s;
      s.name = nm;   s.rst = rst;    s.kn = kn;     s.cycles = cyc;
      s.ep_bits = pb; s.ep_idx = pi; s.ep_vec = pv;
      s.er_bits = rb; s.er_idx = ri; s.er_vec = rv;
      s.lvl_end = lv;
      segs.push_back(s);
   endtask

   // Reference update for one clock edge with the given inputs present.
   task automatic model_edge(input logic [3:0] kn, input logic rst);
      exp_t e;
      logic s;
      e = '0;
      for (int i = 0; i < NK; i++) begin
         if (!rst) begin
            m_sync1[i] = 1'b1;
            m_sync2[i] = 1'b1;
            m_level[i] = 1'b0;
            m_run[i]   = 0;
            m_rep[i]   = 0;
         end else begin
            s = ~m_sync2[i];
            m_sync2[i] = m_sync1[i];
            m_sync1[i] = kn[i];
`ifdef KEY_REPEAT_EN
            // Held and stable: count cycles spent pressed.
            if (m_level[i] && m_run[i] == 0 && s) begin
               m_rep[i]++;
               if (m_rep[i] == RD || (m_rep[i] > RD && (m_rep[i] - RD) % RR == 0))
                  e.pp[i] = 1'b1;
            end
`endif
            if (s != m_level[i]) m_run[i]++;
            else m_run[i] = 0;
            if (m_run[i] == DB) begin
               m_level[i] = ~m_level[i];
               m_run[i]   = 0;
               if (m_level[i]) begin
                  e.pp[i]  = 1'b1;
                  m_rep[i] = 0;
               end else begin
                  e.rp[i] = 1'b1;
               end
            end
         end
         e.lvl[i] = m_level[i];
      end
      sb.push_back(e);
   endtask

   task automatic obs_clear();
      cyc_in_seg = 0;
      obs_pbits = 0; obs_pidx = 0; obs_pvec = '0;
      obs_rbits = 0; obs_ridx = 0; obs_rvec = '0;
   endtask

   task automatic step(input logic [3:0] kn, input logic rst);
      exp_t e;
      key_n = kn;
      reset = rst;
      @(posedge clk);
      model_edge(kn, rst);
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard: got empty queue expected one entry");
      end else begin
         e = sb.pop_front();
         if ({key_level, press_pulse, release_pulse} !== e) begin
            errors++;
            $display("FAIL cycle@%0t level/press/release: got %b/%b/%b expected %b/%b/%b",
                     $time, key_level, press_pulse, release_pulse, e.lvl, e.pp, e.rp);
         end
      end
      cyc_in_seg++;
      obs_pbits += $countones(press_pulse);
      obs_rbits += $countones(release_pulse);
      if (press_pulse != '0 && obs_pidx == 0) begin
         obs_pidx = cyc_in_seg;
         obs_pvec = press_pulse;
      end
      if (release_pulse != '0 && obs_ridx == 0) begin
         obs_ridx = cyc_in_seg;
         obs_rvec = release_pulse;
      end
      if (press_pulse[0]) press_hist.push_back(cyc_in_seg);
   endtask

   initial begin
      // name, rst, key_n, cycles, press{bits,idx,vec}, release{bits,idx,vec}, level_end
      add_seg("reset",     0, 4'hF, 3, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("idle",      1, 4'hF, 5, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("t1_press",  1, 4'h7, 8, 1, 6, 4'h8, 0, 0, 4'h0, 4'h8);
      add_seg("t1_rel",    1, 4'hF, 8, 0, 0, 4'h0, 1, 6, 4'h8, 4'h0);
      for (int i = 0; i < 5; i++) begin
         add_seg("bounce_lo", 1, 4'hE, 2, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
         add_seg("bounce_hi", 1, 4'hF, 2, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      end
      add_seg("bounce_end", 1, 4'hF, 8, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         add_seg("blip_lo", 1, 4'hD, 2, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
         add_seg("blip_hi", 1, 4'hF, 2, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      end
      add_seg("bouncy_hold", 1, 4'hD, 8, 1, 6, 4'h2, 0, 0, 4'h0, 4'h2);
      add_seg("bouncy_rel",  1, 4'hF, 8, 0, 0, 4'h0, 1, 6, 4'h2, 4'h0);
      add_seg("sim_press",   1, 4'h0, 7, 4, 6, 4'hF, 0, 0, 4'h0, 4'hF);
      add_seg("sim_rel2",    1, 4'h4, 6, 0, 0, 4'h0, 1, 6, 4'h4, 4'hB);
      add_seg("sim_relall",  1, 4'hF, 8, 0, 0, 4'h0, 3, 6, 4'hB, 4'h0);
      add_seg("rst_hold",    1, 4'h7, 8, 1, 6, 4'h8, 0, 0, 4'h0, 4'h8);
      add_seg("rst_assert",  0, 4'h7, 2, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("rst_repress", 1, 4'h7, 8, 1, 6, 4'h8, 0, 0, 4'h0, 4'h8);
      add_seg("rst_rel",     1, 4'hF, 8, 0, 0, 4'h0, 1, 6, 4'h8, 4'h0);
      // Reset lands on the edge that would complete the debounce.
      add_seg("race_hold",   1, 4'h7, 5, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("race_rst",    0, 4'h7, 1, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("race_after",  1, 4'hF, 8, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      // Glitch one cycle short of the debounce window, then exactly at it.
      add_seg("glitch3_lo",  1, 4'hE, 3, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("glitch3_hi",  1, 4'hF, 8, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("glitch4_lo",  1, 4'hE, 4, 0, 0, 4'h0, 0, 0, 4'h0, 4'h0);
      add_seg("glitch4_hi",  1, 4'hF, 8, 1, 2, 4'h1, 1, 6, 4'h1, 4'h0);
      add_seg("rg_press",    1, 4'hE, 7, 1, 6, 4'h1, 0, 0, 4'h0, 4'h1);
      add_seg("rg_blip",     1, 4'hF, 3, 0, 0, 4'h0, 0, 0, 4'h0, 4'h1);
      add_seg("rg_hold",     1, 4'hE, 7, 0, 0, 4'h0, 0, 0, 4'h0, 4'h1);
      add_seg("rg_rel",      1, 4'hF, 8, 0, 0, 4'h0, 1, 6, 4'h1, 4'h0);

      foreach (segs[k]) begin
         obs_clear();
         for (int c = 0; c < segs[k].cycles; c++) step(segs[k].kn, segs[k].rst);
         check({segs[k].name, ".press_bits"}, obs_pbits, segs[k].ep_bits);
         check({segs[k].name, ".press_idx"},  obs_pidx,  segs[k].ep_idx);
         check({segs[k].name, ".press_vec"},  int'(obs_pvec), int'(segs[k].ep_vec));
         check({segs[k].name, ".rel_bits"},   obs_rbits, segs[k].er_bits);
         check({segs[k].name, ".rel_idx"},    obs_ridx,  segs[k].er_idx);
         check({segs[k].name, ".rel_vec"},    int'(obs_rvec), int'(segs[k].er_vec));
         check({segs[k].name, ".level_end"},  int'(key_level), int'(segs[k].lvl_end));
      end

      // Long hold on key 0: repeat pulses only with KEY_REPEAT_EN.
`ifdef KEY_REPEAT_EN
      exp_rep = '{6, 16, 19, 22, 25, 28};
`else
      exp_rep = '{6};
`endif
      press_hist.delete();
      obs_clear();
      for (int c = 0; c < 28; c++) step(4'hE, 1'b1);
      for (int c = 0; c < 10; c++) step(4'hF, 1'b1);
      check("hold.press_count", press_hist.size(), exp_rep.size());
      for (int i = 0; i < exp_rep.size(); i++) begin
         if (i < press_hist.size()) check($sformatf("hold.press[%0d]", i), press_hist[i], exp_rep[i]);
      end
      check("hold.rel_idx", obs_ridx, 34);
      check("hold.level_end", int'(key_level), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_pulse_gen.md
Name: key_pulse_gen

Overview:
- Conditions the DE-board pushbuttons (KEY0..KEY3, raw, active-low, bouncing) into clean debounced levels, plus single-cycle press and release pulses.
- Drives the demo FSMs' advance input (e.g. KEY3 "continue"), so each physical press advances exactly one state instead of racing through states while the key is held.
- One debounce channel per key. All outputs are registered in the clk domain.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- CNT_W, 20, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE).
- REPEAT_DELAY, 25000000, cycles a key must be held before the first auto-repeat pulse (used only with KEY_REPEAT_EN).
- REPEAT_RATE, 5000000, cycles between subsequent auto-repeat pulses (used only with KEY_REPEAT_EN).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- key_n  input  NUM_KEYS  raw pushbuttons, active-low, asynchronous to clk.
- key_level  output  NUM_KEYS  debounced state, 1 = pressed.
- press_pulse  output  NUM_KEYS  one-cycle high on each accepted press (and on each repeat if enabled).
- release_pulse  output  NUM_KEYS  one-cycle high on each accepted release.

Behaviour:
- Reset values:
  - key_level, press_pulse and release_pulse are all 0.
  - Synchronizer flops are 1 (released).
  - Counters are 0; every channel is in IDLE.
- Synchronizer: 2-flop chain per key, followed by internal inversion (s = 1 means pressed).
- Per-channel FSM:
  - IDLE (released, stable): if s = 1, go to PRESS_WAIT with cnt = 1; otherwise stay.
  - PRESS_WAIT: if s = 0, return to IDLE with cnt = 0 (bounce rejected). Else if cnt = DEBOUNCE_CYCLES-1, go to PRESSED. Else cnt++.
  - PRESSED (stable): if s = 0, go to RELEASE_WAIT with cnt = 1; otherwise stay.
  - RELEASE_WAIT: if s = 1, return to PRESSED with cnt = 0. Else if cnt = DEBOUNCE_CYCLES-1, go to IDLE. Else cnt++.
- Outputs:
  - key_level = 1 in PRESSED and RELEASE_WAIT.
  - press_pulse = 1 for exactly the one cycle after the PRESS_WAIT→PRESSED transition (registered).
  - release_pulse = 1 for exactly the one cycle after the RELEASE_WAIT→IDLE transition.
- Latency: key_n falls before edge t and stays low. s = 1 is seen at edge t+2. press_pulse and key_level go high in the cycle after edge t+1+DEBOUNCE_CYCLES. Release is symmetric.
- Glitches: any glitch shorter than DEBOUNCE_CYCLES produces no output change and no pulse.
- Channels are fully independent. Simultaneous presses on several keys produce simultaneous pulses on those bits.
- Counter saturation: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-operation:
  - Every channel returns to IDLE immediately; any pending or active pulse is cleared the next cycle.
  - A key still held after reset deasserts is treated as a fresh press: one press_pulse after the full debounce latency.
- Reset-key interplay: reset asserted on the same edge as a debounce completion wins; no pulse is emitted.

Optional Feature:
- Macro: KEY_REPEAT_EN.
- Defined:
  - In PRESSED, a repeat counter runs.
  - After REPEAT_DELAY cycles in PRESSED, press_pulse fires again, then every REPEAT_RATE cycles while the key stays in PRESSED.
  - Entering RELEASE_WAIT freezes the repeat counter. A bounce back to PRESSED resumes it without resetting.
  - Entering IDLE clears the repeat counter.
- Undefined: exactly one press_pulse per accepted press; no repeat counter is synthesized.

Decomposition:
- Package key_pulse_pkg holds:
  - State enum key_state_t (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT) as a 2-bit encoding.
  - Default constants DEBOUNCE_CYCLES_DEF and REPEAT_DELAY_DEF / REPEAT_RATE_DEF.
- Sub-module key_debounce_ch:
  - One channel: synchronizer, FSM, counter, optional repeat logic.
  - Instantiated NUM_KEYS times in a generate loop in key_pulse_gen.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and CNT_W=4 (with KEY_REPEAT_EN: REPEAT_DELAY=10, REPEAT_RATE=3).
1. Clean press: key_n[3] low at cycle 10 and held → key_level[3] = 1 and press_pulse[3] = 1 in cycle 15 only. Release at cycle 30 → release_pulse[3] in cycle 35, key_level[3] = 0 from cycle 35.
2. Bounce rejection: key_n[0] toggles low/high every 2 cycles for 20 cycles, then stays high → no pulse, key_level[0] stays 0.
3. Bouncy press: key_n[1] produces 3 short 2-cycle low blips, then stays low → exactly one press_pulse[1], 5 cycles after the final stable low begins.
4. Simultaneous keys: key_n = 4'b0000 at the same edge → press_pulse = 4'b1111 in one cycle. Release only key 2 → release_pulse = 4'b0100.
5. Reset mid-hold: key 3 in PRESSED, assert reset for 2 cycles while still held → outputs 0 during reset; one new press_pulse[3] 5 cycles after reset deasserts.
6. KEY_REPEAT_EN: hold key 0 for 30 cycles → press_pulses at press+0, +10, +13, +16, …; no pulse after the release begins. Without the macro → a single pulse.
